cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; the next generation of the 16-bit CLA.
- Operand width is split into SEG-bit slices, one slice per pipeline stage.
- Inter-slice carry is registered, so throughput is one operation per clock at any WIDTH.
- Valid/ready handshake on both sides; adds subtract mode and overflow/zero flags for the datapath units that consume it.

Parameters:
- WIDTH, 32: operand and sum width; must be a multiple of SEG.
- SEG, 8: bits per pipeline stage; must be a multiple of 4 (4-bit CLA groups plus group lookahead inside each stage).
- NSTG, WIDTH/SEG (derived, localparam): pipeline depth = latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts the operand set this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  add: carry-out. Sub: 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits, out_valid, sum, cout, ovf and zero go to 0. Stage data registers are cleared. in_ready = 1 once rst is deasserted.
- Operand conditioning at accept:
  - B' = sub ? ~in_b : in_b.
  - c0 = sub ? ~cin : cin.
  - The sub bit is carried down the pipe with its operation.
- Stage k (0..NSTG-1):
  - Computes sum bits [k*SEG +: SEG] with CLA logic from the registered A/B slice and the carry registered by stage k-1 (c0 for k=0).
  - Registers its sum slice, carry-out and the still-unconsumed upper A/B slices (skew buffering).
  - No combinational carry path crosses a stage register.
- Final stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
  - These flags are valid in the same cycle as sum.
- Advance/stall:
  - adv = !out_valid | out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts one step. A transfer occurs when in_valid & in_ready.
  - When adv=0, every stage holds.
  - The pipeline stalls as a whole; bubbles are not compressed.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+NSTG if no stall occurs. Each stall cycle adds one cycle.
- Throughput: one operation per cycle with out_ready held 1.
- Ordering: results leave in acceptance order. No drop and no duplication under any out_ready pattern.
- Outputs hold stable while out_valid=1 and out_ready=0.
- in_valid=0 on an advancing cycle inserts a bubble (stage valid=0). Data of invalid stages is don't-care, but outputs gated by out_valid hold their last value.
- Reset mid-operation: all in-flight operations are discarded. No out_valid follows reset until a new operation is accepted.
- Wrap-around: the sum is modulo 2^WIDTH. Carry propagation across all slice boundaries (e.g. all-ones + 1) must be exact.
- in_valid asserted with in_ready=0: no acceptance. The source must hold its inputs; the block takes no action.

Test Plan (WIDTH=32, SEG=8, NSTG=4 unless stated):
- Reset: hold rst=0 for 2 cycles while driving operands -> out_valid=0, sum=0, cout=0, ovf=0, zero=0. After release, in_ready=1.
- Full carry chain: in_a=0xFFFFFFFF, in_b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, cout=1, zero=1, ovf=0. Also in_a=0x000000FF + 0x00000001 -> sum=0x00000100, cout=0.
- Subtract and overflow:
  - 5-7, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - 0x80000000-1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
  - 0x7FFFFFFF+1 (add) -> sum=0x80000000, ovf=1, cout=0.
- Backpressure: stream 8 back-to-back ops (a=i, b=i<<8), holding out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable. All 8 results arrive in order with a+b correct; none lost or duplicated.
- Reset mid-flight: accept 3 ops, pull rst low for 1 cycle at cycle 2 -> no out_valid for any of them. The next accepted op emerges exactly 4 cycles later.
- Parameter variant: WIDTH=16, SEG=4, 1000 random ops with random sub, cin and out_ready -> every {cout,sum}, ovf and zero matches a behavioural model.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit slice per stage,
// inter-slice carries registered so throughput is one operation per clock.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTG = WIDTH / SEG;
    localparam int NGRP = SEG / 4;

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [SEG+1:0] cla_slice(input logic [SEG-1:0] a,
                                                 input logic [SEG-1:0] b,
                                                 input logic           ci);
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  g;
        logic [SEG:0]    c;
        logic [NGRP:0]   gc;
        logic            gg;
        logic            gp;
        p     = a ^ b;
        g     = a & b;
        c     = '0;
        gc    = '0;
        gc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg = g[4*j+i] | (p[4*j+i] & gg);
                gp = gp & p[4*j+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++)
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
        end
        c[SEG] = gc[NGRP];
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    // Layer k holds the operation about to be processed by stage k. A/B shift
    // right each stage so the slice being added is always in the low SEG bits.
    logic             v_q    [NSTG];
    logic [WIDTH-1:0] a_q    [NSTG];
    logic [WIDTH-1:0] b_q    [NSTG];
    logic             c_q    [NSTG];
    logic [WIDTH-1:0] s_q    [NSTG];
    logic [SEG+1:0]   res    [NSTG];
    logic [WIDTH-1:0] s_next [NSTG];
    logic             adv;

    always_comb begin
        adv = !out_valid || out_ready;
        for (int k = 0; k < NSTG; k++) begin
            res[k] = cla_slice(a_q[k][SEG-1:0], b_q[k][SEG-1:0], c_q[k]);
            // NOTE: full default before the partial write keeps this latch-free.
            s_next[k] = s_q[k];
            s_next[k][k*SEG +: SEG] = res[k][SEG-1:0];
        end
    end

    assign in_ready = adv;

    // NOTE: state updates use <= so every stage samples its neighbour's old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NSTG; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            a_q[0] <= in_a;
            b_q[0] <= sub ? ~in_b : in_b;
            c_q[0] <= sub ^ cin;
            for (int k = 1; k < NSTG; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1] >> SEG;
                b_q[k] <= b_q[k-1] >> SEG;
                c_q[k] <= res[k-1][SEG];
                s_q[k] <= s_next[k-1];
            end
            out_valid <= v_q[NSTG-1];
            // Result registers only update on a real operation, so they hold across bubbles.
            if (v_q[NSTG-1]) begin
                sum  <= s_next[NSTG-1];
                cout <= res[NSTG-1][SEG];
                ovf  <= res[NSTG-1][SEG+1] ^ res[NSTG-1][SEG];
                zero <= (s_next[NSTG-1] == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: a 32/8 instance with directed and random
// traffic, plus a 16/4 instance under random operands and random backpressure.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv32, ir32, ci32, sb32, ov32, or32, co32, of32, z32;
    logic [31:0] a32, b32, s32;
    logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16, z16;
    logic [15:0] a16, b16, s16;

    cla_pipe_adder #(.WIDTH(32), .SEG(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
        .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(of32), .zero(z32)
    );

    cla_pipe_adder #(.WIDTH(16), .SEG(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16), .zero(z16)
    );

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rnd32   = 1'b0;
    bit   rnd16   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.zero = z;
        return e;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t    e;
        longint  m  = longint'(1) << w;
        longint  ua = a;
        longint  ub = b;
        longint  ci = cin;
        longint  sa = (ua >= m / 2) ? ua - m : ua;
        longint  sb = (ub >= m / 2) ? ub - m : ub;
        longint  ur = sub ? ua - ub - ci : ua + ub + ci;
        longint  sr = sub ? sa - sb - ci : sa + sb + ci;
        longint  rm = ur & (m - 1);
        e.sum  = 32'(rm);
        e.cout = sub ? (ur >= 0) : (ur >= m);
        e.ovf  = (sr < -(m / 2)) || (sr > m / 2 - 1);
        e.zero = (rm == 0);
        return e;
    endfunction

    // Monitors: compare the queue head whenever a result is presented; pop on transfer.
    always @(negedge clk) begin
        if (rst && ov32) begin
            if (q32.size() == 0) begin
                check("spurious_out32", ov32, 1'b0);
            end else begin
                e32 = q32[0];
                check("sum32", s32, e32.sum);
                check("cout32", co32, e32.cout);
                check("ovf32", of32, e32.ovf);
                check("zero32", z32, e32.zero);
                if (or32) void'(q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ov16) begin
            if (q16.size() == 0) begin
                check("spurious_out16", ov16, 1'b0);
            end else begin
                e16 = q16[0];
                check("sum16", {16'h0, s16}, e16.sum);
                check("cout16", co16, e16.cout);
                check("ovf16", of16, e16.ovf);
                check("zero16", z16, e16.zero);
                if (or16) void'(q16.pop_front());
            end
        end
    end

    always @(posedge clk) if (rnd32) begin #1; or32 = ($urandom_range(0, 3) != 0); end
    always @(posedge clk) if (rnd16) begin #1; or16 = ($urandom_range(0, 2) != 0); end

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic sub, input exp_t e);
        bit acc = 1'b0;
        a32 = a; b32 = b; ci32 = cin; sb32 = sub; iv32 = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = ir32;
            @(posedge clk);
            #1;
        end
        iv32 = 1'b0;
        if (acc) q32.push_back(e);
        else check("accept32", acc, 1'b1);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, input exp_t e);
        bit acc = 1'b0;
        a16 = a; b16 = b; ci16 = cin; sb16 = sub; iv16 = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = ir16;
            @(posedge clk);
            #1;
        end
        iv16 = 1'b0;
        if (acc) q16.push_back(e);
        else check("accept16", acc, 1'b1);
    endtask

    task automatic drain32();
        for (int n = 0; n < 500 && q32.size() != 0; n++) @(posedge clk);
        #1;
        check("drain32", q32.size(), 0);
    endtask

    task automatic drain16();
        for (int n = 0; n < 500 && q16.size() != 0; n++) @(posedge clk);
        #1;
        check("drain16", q16.size(), 0);
    endtask

    task automatic latency32(input string name);
        int lat = 0;
        for (int n = 0; n < 12 && !ov32; n++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, lat, 4);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [15:0] ha, hb;
        logic        rc, rs;

        rst = 1'b0;
        iv32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h0F0F_0F0F; ci32 = 1'b1; sb32 = 1'b0; or32 = 1'b1;
        iv16 = 1'b1; a16 = 16'hABCD; b16 = 16'h1111; ci16 = 1'b0; sb16 = 1'b1; or16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid32", ov32, 1'b0);
        check("rst_sum32", s32, 32'h0);
        check("rst_cout32", co32, 1'b0);
        check("rst_ovf32", of32, 1'b0);
        check("rst_zero32", z32, 1'b0);
        check("rst_out_valid16", ov16, 1'b0);
        iv32 = 1'b0;
        iv16 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check("in_ready32_after_rst", ir32, 1'b1);
        check("in_ready16_after_rst", ir16, 1'b1);
        @(posedge clk);
        #1;

        // Directed carry-chain, subtract and overflow corners.
        issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        latency32("latency32");
        issue32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0, 1'b0));
        issue32(32'd5,         32'd7,         1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        issue32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        issue32(32'd10,        32'd3,         1'b1, 1'b1, mk(32'h0000_0006, 1'b1, 1'b0, 1'b0));
        issue32(32'd5,         32'd5,         1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        drain32();

        // Back-to-back stream with a 3-cycle output stall in the middle.
        fork
            for (int i = 0; i < 8; i++)
                issue32(32'(i), 32'(i) << 8, 1'b0, 1'b0, model(32, 32'(i), 32'(i) << 8, 1'b0, 1'b0));
            begin
                repeat (6) @(posedge clk);
                #1;
                or32 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready32", ir32, 1'b0);
                    check("stall_out_valid32", ov32, 1'b1);
                    @(posedge clk);
                    #1;
                end
                or32 = 1'b1;
            end
        join
        drain32();

        // Reset with operations in flight: none of them may emerge.
        issue32(32'd100, 32'd1, 1'b0, 1'b0, model(32, 32'd100, 32'd1, 1'b0, 1'b0));
        issue32(32'd200, 32'd2, 1'b0, 1'b0, model(32, 32'd200, 32'd2, 1'b0, 1'b0));
        issue32(32'd300, 32'd3, 1'b0, 1'b0, model(32, 32'd300, 32'd3, 1'b0, 1'b0));
        rst = 1'b0;
        q32.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_reset_idle32", ov32, 1'b0);
        end
        @(posedge clk);
        #1;
        issue32(32'h1357_9BDF, 32'h0246_8ACE, 1'b1, 1'b0,
                model(32, 32'h1357_9BDF, 32'h0246_8ACE, 1'b1, 1'b0));
        latency32("latency32_after_reset");
        drain32();

        // Random 32-bit traffic with bubbles and random backpressure.
        rnd32 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = pick32();
            rb = pick32();
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            issue32(ra, rb, rc, rs, model(32, ra, rb, rc, rs));
        end
        rnd32 = 1'b0;
        @(posedge clk);
        #2;
        or32 = 1'b1;
        drain32();

        // 16-bit / 4-bit-slice variant: 1000 random operations.
        rnd16 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ha = 16'($urandom);
            hb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
            issue16(ha, hb, rc, rs, model(16, {16'h0, ha}, {16'h0, hb}, rc, rs));
        end
        rnd16 = 1'b0;
        @(posedge clk);
        #2;
        or16 = 1'b1;
        drain16();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
